// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC capture engine.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: FSM state enum, trigger-mode enum, and LANE_W (the width
// each sample is zero-extended to before packing into a 32-bit word).
package adc_cap_pkg;

  localparam int LANE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } cap_state_t;

  typedef enum logic [1:0] {
    TRIG_IMM  = 2'd0,
    TRIG_RISE = 2'd1,
    TRIG_FALL = 2'd2,
    TRIG_RSVD = 2'd3
  } trig_mode_t;

endpackage

// File: rtl/adc_cap_packer.sv
// Packs kept sample sets into 32-bit words of two 16-bit lanes.
// Latency: combinational word_vld/word_dat; NUM_CH=4 second word one cycle later.
// Backpressure: none; a set offered while word B is pending is dropped and flagged on overrun.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   clr           : start-of-capture clear (lane pointer, pending word B)
//   set_vld       : set_data holds a kept sample set to be packed
//   set_data      : NUM_CH samples, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   word_vld      : word_dat is a complete word this cycle
//   word_dat      : {hi lane, lo lane}
//   overrun       : pulse, set_vld arrived while word B was still pending
// Legal NUM_CH values are 1, 2 and 4; any other value builds the 4-channel packer.
module adc_cap_packer
  import adc_cap_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       set_vld,
  input  logic [NUM_CH*SAMPLE_W-1:0] set_data,
  output logic                       word_vld,
  output logic [31:0]                word_dat,
  output logic                       overrun
);

  logic [LANE_W-1:0] lane [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign lane[k] = LANE_W'(set_data[k*SAMPLE_W +: SAMPLE_W]);
  end

  if (NUM_CH == 1) begin : g_one
    // Two consecutive kept samples make one word: lo first, then hi.
    logic              hi_sel;
    logic [LANE_W-1:0] lo_hold;

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        hi_sel  <= 1'b0;
        lo_hold <= '0;
      end else if (set_vld) begin
        hi_sel <= ~hi_sel;
        if (!hi_sel) lo_hold <= lane[0];
      end
    end

    assign word_vld = set_vld & hi_sel;
    assign word_dat = {lane[0], lo_hold};
    assign overrun  = 1'b0;

  end else if (NUM_CH == 2) begin : g_two
    logic unused_ctl;

    assign word_vld   = set_vld;
    assign word_dat   = {lane[1], lane[0]};
    assign overrun    = 1'b0;
    assign unused_ctl = &{1'b0, clk, rst, clr};

  end else begin : g_four
    // Word A goes out with the set; word B is held and goes out next cycle.
    // The output slot is busy for that cycle, so a new set then is lost.
    logic        b_pend;
    logic [31:0] b_hold;

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        b_pend <= 1'b0;
        b_hold <= '0;
      end else if (b_pend) begin
        b_pend <= 1'b0;
      end else if (set_vld) begin
        b_pend <= 1'b1;
        b_hold <= {lane[3], lane[2]};
      end
    end

    assign word_vld = b_pend | set_vld;
    assign word_dat = b_pend ? b_hold : {lane[1], lane[0]};
    assign overrun  = b_pend & set_vld;
  end

endmodule

// File: rtl/adc_capture_engine.sv
// Multi-channel ADC capture engine writing packed sample words into DMEM.
// Latency: mem_* registered, 1 cycle after the completing smp_vld (NUM_CH=4 word B one cycle later).
// Backpressure: none on the ADC side; NUM_CH=4 sets arriving while word B is pending are dropped (st_overrun).
//
// Build option: define ADC_CAPTURE_TRIG_EN to build the threshold trigger
// (modes 1/2, trigger-channel mux, previous-sample register). Without it the
// cfg_trig_* inputs are ignored and ARM always lasts one cycle.
//
// Ports:
//   sys_clk, sys_rst           : clock, synchronous active-high reset
//   smp_data, smp_vld          : ADC sample set, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   cfg_start (rising edge)    : start a capture when idle
//   cfg_abort (level)          : end a capture in progress
//   cfg_depth/decim/trig_*     : capture setup, latched at the start edge
//   mem_we, mem_addr, mem_data : DMEM port 2 write
//   st_busy/done/aborted/overrun/wcount : status
module adc_capture_engine
  import adc_cap_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int SAMPLE_W  = 12,
  parameter int ADDR_W    = 13,
  parameter int BASE_ADDR = 0,
  parameter int DECIM_W   = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [NUM_CH*SAMPLE_W-1:0] smp_data,
  input  logic                       smp_vld,
  input  logic                       cfg_start,
  input  logic                       cfg_abort,
  input  logic [ADDR_W-1:0]          cfg_depth,
  input  logic [DECIM_W-1:0]         cfg_decim,
  input  logic [1:0]                 cfg_trig_mode,
  input  logic [1:0]                 cfg_trig_ch,
  input  logic [SAMPLE_W-1:0]        cfg_trig_lvl,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_data,
  output logic                       st_busy,
  output logic                       st_done,
  output logic                       st_aborted,
  output logic                       st_overrun,
  output logic [ADDR_W:0]            st_wcount
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  cap_state_t          state, state_nxt;
  logic                start_q;
  logic                start_go;
  logic                busy;
  logic                abort_go;
  logic                kept;
  logic                arm_take;   // kept set in ARM that is captured (trigger set)
  logic                arm_exit;   // ARM may move on to CAPT this cycle
  logic                cap_set;
  logic                accept;
  logic                final_wr;
  logic [ADDR_W-1:0]   depth_r;
  logic [DECIM_W-1:0]  decim_r;
  logic [DECIM_W-1:0]  dec_cnt;
  logic [ADDR_W:0]     depth_full;
  logic [ADDR_W:0]     wcount_inc;
  logic                word_vld;
  logic [31:0]         word_dat;
  logic                pk_overrun;

  assign busy       = (state == ST_ARM) || (state == ST_CAPT);
  assign st_busy    = busy;
  assign start_go   = cfg_start & ~start_q & (state == ST_IDLE);
  assign abort_go   = busy & cfg_abort;
  assign kept       = busy & smp_vld & (dec_cnt == '0);
  // Depth 0 encodes a full 2^ADDR_W-word buffer.
  assign depth_full = (depth_r == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, depth_r};
  assign wcount_inc = st_wcount + (ADDR_W+1)'(1);

  // ---------------------------------------------------------------- trigger
`ifdef ADC_CAPTURE_TRIG_EN
  trig_mode_t          mode_r;
  logic [1:0]          trig_ch_r;
  logic [SAMPLE_W-1:0] lvl_r;
  logic [SAMPLE_W-1:0] prev_smp;
  logic [SAMPLE_W-1:0] trig_smp;
  logic                prev_vld;
  logic                trig_imm;
  logic                trig_hit;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_r    <= TRIG_IMM;
      trig_ch_r <= '0;
      lvl_r     <= '0;
      prev_smp  <= '0;
      prev_vld  <= 1'b0;
    end else if (start_go) begin
      mode_r    <= trig_mode_t'(cfg_trig_mode);
      trig_ch_r <= cfg_trig_ch & 2'(NUM_CH-1);
      lvl_r     <= cfg_trig_lvl;
      prev_vld  <= 1'b0;
    end else if ((state == ST_ARM) && kept) begin
      // Only kept (post-decimation) sets feed the edge detector.
      prev_smp <= trig_smp;
      prev_vld <= 1'b1;
    end
  end

  assign trig_smp = smp_data[trig_ch_r*SAMPLE_W +: SAMPLE_W];

  always_comb begin
    trig_imm = (mode_r == TRIG_IMM) || (mode_r == TRIG_RSVD);
    trig_hit = 1'b0;
    case (mode_r)
      TRIG_RISE: trig_hit = prev_vld && (prev_smp < lvl_r) && (trig_smp >= lvl_r);
      TRIG_FALL: trig_hit = prev_vld && (prev_smp >= lvl_r) && (trig_smp < lvl_r);
      default:   trig_hit = 1'b1;
    endcase
  end

  assign arm_take = kept & trig_hit;
  assign arm_exit = trig_imm | arm_take;
`else
  logic unused_trig;

  assign unused_trig = &{1'b0, cfg_trig_mode, cfg_trig_ch, cfg_trig_lvl};
  assign arm_take    = kept;
  assign arm_exit    = 1'b1;
`endif

  // In immediate mode a kept set arriving during the single ARM cycle is
  // treated as the trigger set and captured, so no sample is lost.
  assign cap_set  = ~abort_go & (((state == ST_CAPT) & kept) | ((state == ST_ARM) & arm_take));
  assign accept   = word_vld & busy & ~abort_go;
  assign final_wr = accept & (wcount_inc == depth_full);

  adc_cap_packer #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W)
  ) u_packer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .clr      (start_go),
    .set_vld  (cap_set),
    .set_data (smp_data),
    .word_vld (word_vld),
    .word_dat (word_dat),
    .overrun  (pk_overrun)
  );

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_go) state_nxt = ST_ARM;
      ST_ARM: begin
        // A capture can complete from ARM when depth is one word.
        if (abort_go || final_wr) state_nxt = ST_DONE;
        else if (arm_exit)        state_nxt = ST_CAPT;
      end
      ST_CAPT: if (abort_go || final_wr) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      start_q    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_data   <= '0;
      st_done    <= 1'b0;
      st_aborted <= 1'b0;
      st_overrun <= 1'b0;
      st_wcount  <= '0;
      depth_r    <= '0;
      decim_r    <= '0;
      dec_cnt    <= '0;
    end else begin
      start_q <= cfg_start;
      mem_we  <= 1'b0;

      if (start_go) begin
        st_done    <= 1'b0;
        st_aborted <= 1'b0;
        st_overrun <= 1'b0;
        st_wcount  <= '0;
        dec_cnt    <= '0;
        mem_addr   <= BASE;
        depth_r    <= cfg_depth;
        decim_r    <= cfg_decim;
      end

      if (busy && smp_vld) begin
        dec_cnt <= (dec_cnt == '0) ? decim_r : dec_cnt - DECIM_W'(1);
      end

      if (accept) begin
        mem_we    <= 1'b1;
        mem_addr  <= BASE + st_wcount[ADDR_W-1:0];   // wraps modulo 2^ADDR_W
        mem_data  <= word_dat;
        st_wcount <= wcount_inc;
      end

      if (pk_overrun) st_overrun <= 1'b1;
      if (abort_go)   st_aborted <= 1'b1;
      if (busy && (state_nxt == ST_DONE)) st_done <= 1'b1;
    end
  end

endmodule
